conv_fprop2_mul_rr_arbiter: RTL and testbench

- Shares one unsigned 11x6 -> 16-bit multiply datapath among NUM_REQ requesters inside conv_fprop2, e.g. the address-offset and index-scaling producers.
- Arbitrates round-robin.
- Registers one product per cycle into a single tagged response channel.
- Uses valid/ready handshakes on both sides, so producers never need their own multiplier instance.

---
 rtl/conv_fprop2_mul_rr_arbiter.sv | 122 ++++++++++++
 tb/tb_conv_fprop2_mul_rr_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/conv_fprop2_mul_rr_arbiter.sv
// Round-robin arbiter sharing one unsigned A_W x B_W multiplier among NUM_REQ requesters.
// Optional saturation instead of truncation: define CONV_FPROP2_MUL_SAT_EN (adds sat_flag).
module conv_fprop2_mul_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int A_W     = 11,
  parameter int B_W     = 6,
  parameter int P_W     = 16,
  parameter int ID_W    = 2
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [P_W-1:0]         rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic [15:0]            accept_cnt
`ifdef CONV_FPROP2_MUL_SAT_EN
  ,
  output logic                   sat_flag
`endif
);

  localparam int FULL_W = A_W + B_W;

  logic                r_vld_p1;
  logic [P_W-1:0]      r_data_p1;
  logic [ID_W-1:0]     r_id_p1;
  logic [15:0]         r_cnt;
  logic [ID_W-1:0]     r_ptr;

  logic                w_found;
  logic [ID_W-1:0]     w_grant;
  logic [ID_W:0]       w_sum;
  logic                w_can_accept;
  logic                w_accept;
  logic [A_W-1:0]      w_a;
  logic [B_W-1:0]      w_b;
  logic [FULL_W-1:0]   w_prod;
  logic [ID_W-1:0]     w_ptr_next;

  function automatic logic [P_W-1:0] fit_product(input logic [FULL_W-1:0] p);
`ifdef CONV_FPROP2_MUL_SAT_EN
    if (|(p >> P_W)) return '1;
`endif
    return P_W'(p);
  endfunction

  // Stage 0: grant scan from the pointer upward, operand mux, multiply
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (w_sum >= (ID_W+1)'(NUM_REQ)) w_sum = w_sum - (ID_W+1)'(NUM_REQ);
      if (!w_found && req_valid[w_sum[ID_W-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_sum[ID_W-1:0];
      end
    end
  end

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant == ID_W'(i)) begin
        w_a = req_a[i*A_W +: A_W];
        w_b = req_b[i*B_W +: B_W];
      end
    end
  end

  assign w_prod       = {{B_W{1'b0}}, w_a} * {{A_W{1'b0}}, w_b};
  assign w_can_accept = !r_vld_p1 || rsp_ready;
  // Reset gates ready combinationally so nothing is offered while ap_rst is high.
  assign w_accept     = !ap_rst && w_found && w_can_accept;
  assign w_ptr_next   = (w_grant == ID_W'(NUM_REQ-1)) ? '0 : w_grant + 1'b1;

  always_comb begin
    req_ready = '0;
    if (w_accept) req_ready[w_grant] = 1'b1;
  end

  // Stage 1: one-deep output register, refills in the same cycle it drains
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
      r_id_p1   <= '0;
      r_cnt     <= '0;
      r_ptr     <= '0;
    end else if (w_accept) begin
      r_vld_p1  <= 1'b1;
      r_data_p1 <= fit_product(w_prod);
      r_id_p1   <= w_grant;
      r_cnt     <= r_cnt + 16'd1;
      r_ptr     <= w_ptr_next;
    end else if (rsp_ready) begin
      r_vld_p1  <= 1'b0;
    end
  end

`ifdef CONV_FPROP2_MUL_SAT_EN
  logic r_sat;
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) r_sat <= 1'b0;
    else if (w_accept && |(w_prod >> P_W)) r_sat <= 1'b1;
  end
  assign sat_flag = r_sat;
`endif

  assign rsp_valid  = r_vld_p1;
  assign rsp_data   = r_data_p1;
  assign rsp_id     = r_id_p1;
  assign accept_cnt = r_cnt;

endmodule

// File: tb/tb_conv_fprop2_mul_rr_arbiter.sv
// Directed, table-driven bench for the round-robin shared multiplier arbiter.
module tb_conv_fprop2_mul_rr_arbiter;
  localparam int NUM_REQ = 4;
  localparam int A_W = 11;
  localparam int B_W = 6;
  localparam int P_W = 16;
  localparam int ID_W = 2;

  logic                   ap_clk = 1'b0;
  logic                   ap_rst;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*A_W-1:0] req_a;
  logic [NUM_REQ*B_W-1:0] req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [P_W-1:0]         rsp_data;
  logic [ID_W-1:0]        rsp_id;
  logic [15:0]            accept_cnt;
`ifdef CONV_FPROP2_MUL_SAT_EN
  logic                   sat_flag;
`endif

  conv_fprop2_mul_rr_arbiter #(
    .NUM_REQ(NUM_REQ), .A_W(A_W), .B_W(B_W), .P_W(P_W), .ID_W(ID_W)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .accept_cnt(accept_cnt)
`ifdef CONV_FPROP2_MUL_SAT_EN
    ,
    .sat_flag  (sat_flag)
`endif
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct packed {
    logic [3:0]  vld;
    logic [43:0] a;
    logic [23:0] b;
    logic        rdy;
    logic [3:0]  e_ready;
    logic        e_valid;
    logic [15:0] e_data;
    logic [1:0]  e_id;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] vld, input logic [43:0] a, input logic [23:0] b,
                     input logic rdy, input logic [3:0] er, input logic ev,
                     input logic [15:0] ed, input logic [1:0] eid, input logic [15:0] ecnt);
    vec_t v;
    v.vld = vld; v.a = a; v.b = b; v.rdy = rdy;
    v.e_ready = er; v.e_valid = ev; v.e_data = ed; v.e_id = eid; v.e_cnt = ecnt;
    vecs.push_back(v);
  endtask

  localparam logic [43:0] A_RR = {11'd400, 11'd300, 11'd200, 11'd100};
  localparam logic [23:0] B_RR = {6'd4, 6'd3, 6'd2, 6'd50};
  localparam logic [43:0] A_T  = {11'd400, 11'd300, 11'd200, 11'd2047};
  localparam logic [23:0] B_T  = {6'd4, 6'd3, 6'd2, 6'd63};
  localparam logic [43:0] A_BP = {11'd400, 11'd300, 11'd200, 11'd7};
  localparam logic [23:0] B_BP = {6'd4, 6'd3, 6'd2, 6'd9};
`ifdef CONV_FPROP2_MUL_SAT_EN
  localparam logic [15:0] BIG = 16'hFFFF;
`else
  localparam logic [15:0] BIG = 16'hF7C1;
`endif

  initial begin
    // round robin, all four valid: 0,1,2,3,0
    add(4'hF, A_RR, B_RR, 1'b1, 4'b0001, 1'b1, 16'd5000, 2'd0, 16'd1);
    add(4'hF, A_RR, B_RR, 1'b1, 4'b0010, 1'b1, 16'd400,  2'd1, 16'd2);
    add(4'hF, A_RR, B_RR, 1'b1, 4'b0100, 1'b1, 16'd900,  2'd2, 16'd3);
    add(4'hF, A_RR, B_RR, 1'b1, 4'b1000, 1'b1, 16'd1600, 2'd3, 16'd4);
    add(4'hF, A_RR, B_RR, 1'b1, 4'b0001, 1'b1, 16'd5000, 2'd0, 16'd5);
    // single request with ptr=1 wraps round to requester 0
    add(4'h1, A_RR, B_RR, 1'b1, 4'b0001, 1'b1, 16'd5000, 2'd0, 16'd6);
    // pointer skip, only 1 and 3 valid
    add(4'hA, A_RR, B_RR, 1'b1, 4'b0010, 1'b1, 16'd400,  2'd1, 16'd7);
    add(4'hA, A_RR, B_RR, 1'b1, 4'b1000, 1'b1, 16'd1600, 2'd3, 16'd8);
    add(4'hA, A_RR, B_RR, 1'b1, 4'b0010, 1'b1, 16'd400,  2'd1, 16'd9);
    add(4'hA, A_RR, B_RR, 1'b1, 4'b1000, 1'b1, 16'd1600, 2'd3, 16'd10);
    // full product 128961
    add(4'h1, A_T,  B_T,  1'b1, 4'b0001, 1'b1, BIG,      2'd0, 16'd11);
    // drain without refill keeps data/id
    add(4'h0, A_T,  B_T,  1'b1, 4'b0000, 1'b0, BIG,      2'd0, 16'd11);
    // backpressure: 7*9 held for 3 cycles, then same-cycle refill
    add(4'h1, A_BP, B_BP, 1'b1, 4'b0001, 1'b1, 16'd63,   2'd0, 16'd12);
    add(4'h4, A_BP, B_BP, 1'b0, 4'b0000, 1'b1, 16'd63,   2'd0, 16'd12);
    add(4'h4, A_BP, B_BP, 1'b0, 4'b0000, 1'b1, 16'd63,   2'd0, 16'd12);
    add(4'h4, A_BP, B_BP, 1'b0, 4'b0000, 1'b1, 16'd63,   2'd0, 16'd12);
    add(4'h4, A_BP, B_BP, 1'b1, 4'b0100, 1'b1, 16'd900,  2'd2, 16'd13);
    add(4'h0, A_BP, B_BP, 1'b1, 4'b0000, 1'b0, 16'd900,  2'd2, 16'd13);

    ap_rst = 1'b1; req_valid = '0; req_a = A_RR; req_b = B_RR; rsp_ready = 1'b1;
    repeat (2) @(posedge ap_clk);
    #1;
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst req_ready", 32'(req_ready), 32'd0);
    chk("rst accept_cnt", 32'(accept_cnt), 32'd0);
    chk("rst rsp_data", 32'(rsp_data), 32'd0);
`ifdef CONV_FPROP2_MUL_SAT_EN
    chk("rst sat_flag", 32'(sat_flag), 32'd0);
`endif

    // first grant after release goes to requester 0; then hold it under backpressure
    @(negedge ap_clk);
    ap_rst = 1'b0; req_valid = 4'hF; rsp_ready = 1'b0;
    #1 chk("release first grant", 32'(req_ready), 32'b0001);
    @(posedge ap_clk);
    #1;
    chk("pre-reset rsp_valid", 32'(rsp_valid), 32'd1);
    chk("pre-reset cnt", 32'(accept_cnt), 32'd1);

    // asynchronous reset mid-cycle with all requesters valid
    @(posedge ap_clk);
    #3 ap_rst = 1'b1;
    #1;
    chk("async rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("async rst req_ready", 32'(req_ready), 32'd0);
    chk("async rst cnt", 32'(accept_cnt), 32'd0);
    chk("async rst data", 32'(rsp_data), 32'd0);
    chk("async rst id", 32'(rsp_id), 32'd0);
    @(negedge ap_clk);
    ap_rst = 1'b0; req_valid = '0; rsp_ready = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge ap_clk);
      req_valid = vecs[i].vld;
      req_a     = vecs[i].a;
      req_b     = vecs[i].b;
      rsp_ready = vecs[i].rdy;
      #1 chk($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(vecs[i].e_ready));
      @(posedge ap_clk);
      #1;
      chk($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d rsp_data", i), 32'(rsp_data), 32'(vecs[i].e_data));
      chk($sformatf("v%0d rsp_id", i), 32'(rsp_id), 32'(vecs[i].e_id));
      chk($sformatf("v%0d accept_cnt", i), 32'(accept_cnt), 32'(vecs[i].e_cnt));
    end
`ifdef CONV_FPROP2_MUL_SAT_EN
    chk("sat_flag sticky", 32'(sat_flag), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
